cpu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 16-bit CPU.
- Steps each instruction through fetch, decode, execute, optional data-memory access and writeback.
- Drives the program counter's enable, write and source-select controls, plus memory request, IR load, ALU enable and register write-enable.
- Also handles halt, interrupt entry and memory-handshake timeout.

---
 rtl/cpu_sequencer_pkg.sv | 18 +
 rtl/cpu_sequencer_if.sv | 26 ++
 rtl/cpu_sequencer_mem_wait_timer.sv | 28 ++
 rtl/cpu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the CPU control path: sequencer state encoding and
// PC source-select values.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_IRQ       = 3'd5,
        ST_HALT      = 3'd6
    } seq_state_e;

    localparam logic PC_SRC_BRANCH = 1'b0;
    localparam logic PC_SRC_IRQ    = 1'b1;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Memory handshake and datapath control strobes between the sequencer
// (master) and the datapath/memory side (slave).
interface cpu_sequencer_if;
    logic I_mem_ready;
    logic O_mem_req;
    logic O_mem_sel;
    logic O_pc_enable;
    logic O_pc_write;
    logic O_pc_sel;
    logic O_ir_load;
    logic O_decode_en;
    logic O_alu_en;
    logic O_reg_we;

    modport master (
        input  I_mem_ready,
        output O_mem_req, O_mem_sel, O_pc_enable, O_pc_write, O_pc_sel,
               O_ir_load, O_decode_en, O_alu_en, O_reg_we
    );

    modport slave (
        output I_mem_ready,
        input  O_mem_req, O_mem_sel, O_pc_enable, O_pc_write, O_pc_sel,
               O_ir_load, O_decode_en, O_alu_en, O_reg_we
    );
endinterface

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting on a memory handshake; saturates at the limit
// so it never wraps while the sequencer decides what to do.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic I_clk,
    input  logic I_reset,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);
    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(MEM_TIMEOUT);
    // With the timeout disabled the counter just parks at all-ones.
    localparam logic [TIMEOUT_W-1:0] SAT   = (MEM_TIMEOUT == 0) ? '1 : LIMIT;

    logic [TIMEOUT_W-1:0] count_reg;

    always_ff @(posedge I_clk) begin
        if (I_reset || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != SAT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign limit_hit = (MEM_TIMEOUT != 0) && (count_reg == LIMIT);
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU: fetch, decode, execute,
// optional memory access, writeback, plus halt, interrupt entry and timeout.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic              I_clk,
    input  logic              I_reset,
    cpu_sequencer_if.master   bus,
    input  logic              I_is_mem,
    input  logic              I_is_branch,
    input  logic              I_is_halt,
    input  logic              I_writes_reg,
    input  logic              I_branch_taken,
    input  logic              I_irq,
    input  logic              I_irq_en,
    output logic              O_irq_ack,
    output logic              O_halted,
    output logic              O_fault,
    output logic [2:0]        O_state
);
    seq_state_e state_reg, state_next;
    logic is_mem_reg, is_mem_next;
    logic is_branch_reg, is_branch_next;
    logic writes_reg_reg, writes_reg_next;
    logic branch_done_reg, branch_done_next;
    logic fault_reg, fault_next;

    logic waiting, timer_clear, timer_enable, limit_hit;
    logic pc_enable, pc_write, pc_sel, mem_req, mem_sel;
    logic ir_load, decode_en, alu_en, reg_we, irq_ack;
    logic irq_take;

    assign waiting      = (state_reg == ST_FETCH) || (state_reg == ST_MEMORY);
    assign timer_enable = waiting && !bus.I_mem_ready;
    assign timer_clear  = !waiting || bus.I_mem_ready;
    assign irq_take     = I_irq && I_irq_en;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TIMEOUT_W   (TIMEOUT_W)
    ) u_timer (
        .I_clk     (I_clk),
        .I_reset   (I_reset),
        .clear     (timer_clear),
        .enable    (timer_enable),
        .limit_hit (limit_hit)
    );

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_reg       <= ST_FETCH;
            is_mem_reg      <= 1'b0;
            is_branch_reg   <= 1'b0;
            writes_reg_reg  <= 1'b0;
            branch_done_reg <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            is_mem_reg      <= is_mem_next;
            is_branch_reg   <= is_branch_next;
            writes_reg_reg  <= writes_reg_next;
            branch_done_reg <= branch_done_next;
            fault_reg       <= fault_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        is_mem_next      = is_mem_reg;
        is_branch_next   = is_branch_reg;
        writes_reg_next  = writes_reg_reg;
        branch_done_next = branch_done_reg;
        fault_next       = fault_reg;
        pc_enable        = 1'b0;
        pc_write         = 1'b0;
        pc_sel           = PC_SRC_BRANCH;
        mem_req          = 1'b0;
        mem_sel          = 1'b0;
        ir_load          = 1'b0;
        decode_en        = 1'b0;
        alu_en           = 1'b0;
        reg_we           = 1'b0;
        irq_ack          = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.I_mem_ready) begin
                    ir_load    = 1'b1;
                    state_next = ST_DECODE;
                end else if (limit_hit) begin
                    fault_next = 1'b1;
                    state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                decode_en       = 1'b1;
                is_mem_next     = I_is_mem;
                is_branch_next  = I_is_branch;
                writes_reg_next = I_writes_reg;
                state_next      = I_is_halt ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_en = 1'b1;
                if (is_branch_reg && I_branch_taken) begin
                    pc_enable        = 1'b1;
                    pc_write         = 1'b1;
                    pc_sel           = PC_SRC_BRANCH;
                    branch_done_next = 1'b1;
                end
                state_next = is_mem_reg ? ST_MEMORY : ST_WRITEBACK;
            end
            ST_MEMORY: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                if (bus.I_mem_ready) begin
                    state_next = ST_WRITEBACK;
                end else if (limit_hit) begin
                    fault_next = 1'b1;
                    state_next = ST_HALT;
                end
            end
            ST_WRITEBACK: begin
                reg_we           = writes_reg_reg;
                // A taken branch already loaded the PC; skip the sequential step.
                pc_enable        = !branch_done_reg;
                branch_done_next = 1'b0;
                state_next       = irq_take ? ST_IRQ : ST_FETCH;
            end
            ST_IRQ: begin
                pc_enable  = 1'b1;
                pc_write   = 1'b1;
                pc_sel     = PC_SRC_IRQ;
                irq_ack    = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                if (irq_take && !fault_reg) begin
                    state_next = ST_IRQ;
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

    assign bus.O_pc_enable = pc_enable;
    assign bus.O_pc_write  = pc_write;
    assign bus.O_pc_sel    = pc_sel;
    assign bus.O_mem_req   = mem_req;
    assign bus.O_mem_sel   = mem_sel;
    assign bus.O_ir_load   = ir_load;
    assign bus.O_decode_en = decode_en;
    assign bus.O_alu_en    = alu_en;
    assign bus.O_reg_we    = reg_we;
    assign O_irq_ack       = irq_ack;
    assign O_halted        = (state_reg == ST_HALT);
    assign O_fault         = fault_reg;
    assign O_state         = state_reg;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios with literal expectations, then
// random stimulus checked every cycle against a behavioural model.
module tb_cpu_sequencer;
    localparam int MT = 4;

    logic       I_clk = 1'b0;
    logic       I_reset = 1'b0;
    logic       I_is_mem = 1'b0, I_is_branch = 1'b0, I_is_halt = 1'b0;
    logic       I_writes_reg = 1'b0, I_branch_taken = 1'b0;
    logic       I_irq = 1'b0, I_irq_en = 1'b0;
    logic       O_irq_ack, O_halted, O_fault;
    logic [2:0] O_state;

    cpu_sequencer_if bus();

    cpu_sequencer #(.MEM_TIMEOUT(MT), .TIMEOUT_W(8)) dut (
        .I_clk          (I_clk),
        .I_reset        (I_reset),
        .bus            (bus.master),
        .I_is_mem       (I_is_mem),
        .I_is_branch    (I_is_branch),
        .I_is_halt      (I_is_halt),
        .I_writes_reg   (I_writes_reg),
        .I_branch_taken (I_branch_taken),
        .I_irq          (I_irq),
        .I_irq_en       (I_irq_en),
        .O_irq_ack      (O_irq_ack),
        .O_halted       (O_halted),
        .O_fault        (O_fault),
        .O_state        (O_state)
    );

    always #5 I_clk = ~I_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, return at the falling edge.
    task automatic cyc(input bit rst, input bit rdy, input bit mem, input bit br,
                       input bit hlt, input bit wr, input bit tk, input bit irq,
                       input bit en);
        @(posedge I_clk);
        #1;
        I_reset = rst; bus.I_mem_ready = rdy; I_is_mem = mem; I_is_branch = br;
        I_is_halt = hlt; I_writes_reg = wr; I_branch_taken = tk; I_irq = irq;
        I_irq_en = en;
        @(negedge I_clk);
    endtask

    // Behavioural model: instruction phase numbers as listed for O_state.
    int m_state = 0;
    int m_cnt   = 0;
    bit m_mem, m_br, m_wr, m_bd, m_fault;
    bit m_valid = 1'b0;

    always @(negedge I_clk) begin
        bit e_pce, e_pcw, e_pcs, e_req, e_sel, e_ir, e_dec, e_alu, e_we, e_ack;
        bit n_mem, n_br, n_wr, n_bd, n_fault, hit, rdy;
        int nx;
        logic [14:0] exp_v, act_v;
        {e_pce, e_pcw, e_pcs, e_req, e_sel, e_ir, e_dec, e_alu, e_we, e_ack} = '0;
        n_mem = m_mem; n_br = m_br; n_wr = m_wr; n_bd = m_bd; n_fault = m_fault;
        nx  = m_state;
        rdy = bus.I_mem_ready;
        hit = (MT != 0) && (m_cnt == MT);
        case (m_state)
            0: begin
                e_req = 1;
                if (rdy) begin e_ir = 1; nx = 1; end
                else if (hit) begin n_fault = 1; nx = 6; end
            end
            1: begin
                e_dec = 1;
                n_mem = I_is_mem; n_br = I_is_branch; n_wr = I_writes_reg;
                nx = I_is_halt ? 6 : 2;
            end
            2: begin
                e_alu = 1;
                if (m_br && I_branch_taken) begin e_pce = 1; e_pcw = 1; n_bd = 1; end
                nx = m_mem ? 3 : 4;
            end
            3: begin
                e_req = 1; e_sel = 1;
                if (rdy) nx = 4;
                else if (hit) begin n_fault = 1; nx = 6; end
            end
            4: begin
                e_we = m_wr; e_pce = !m_bd; n_bd = 0;
                nx = (I_irq && I_irq_en) ? 5 : 0;
            end
            5: begin
                e_pce = 1; e_pcw = 1; e_pcs = 1; e_ack = 1; nx = 0;
            end
            default: begin
                if (!m_fault && I_irq && I_irq_en) nx = 5;
            end
        endcase
        if (m_valid) begin
            exp_v = {3'(m_state), (m_state == 6), m_fault, e_pce, e_pcw, e_pcs, e_req,
                     e_sel, e_ir, e_dec, e_alu, e_we, e_ack};
            act_v = {O_state, O_halted, O_fault, bus.O_pc_enable, bus.O_pc_write,
                     bus.O_pc_sel, bus.O_mem_req, bus.O_mem_sel, bus.O_ir_load,
                     bus.O_decode_en, bus.O_alu_en, bus.O_reg_we, O_irq_ack};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model @%0t: actual=%h required=%h", $time, act_v, exp_v);
            end
        end
        if (I_reset) begin
            m_state = 0; m_cnt = 0; m_mem = 0; m_br = 0; m_wr = 0; m_bd = 0;
            m_fault = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_cnt = ((m_state == 0 || m_state == 3) && !rdy && nx == m_state) ? m_cnt + 1 : 0;
            m_state = nx; m_mem = n_mem; m_br = n_br; m_wr = n_wr; m_bd = n_bd;
            m_fault = n_fault;
        end
    end

    initial begin
        bus.I_mem_ready = 1'b0;
        // Reset, then ALU instruction with ready on the 3rd fetch cycle
        cyc(1,0,0,0,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,0,0,0);
        chk("t1_state_f1", O_state, 0); chk("t1_req", bus.O_mem_req, 1);
        chk("t1_fault", O_fault, 0); chk("t1_ir_idle", bus.O_ir_load, 0);
        cyc(0,0,0,0,0,0,0,0,0); chk("t1_state_f2", O_state, 0);
        cyc(0,1,0,0,0,0,0,0,0); chk("t1_state_f3", O_state, 0); chk("t1_ir", bus.O_ir_load, 1);
        cyc(0,0,0,0,0,1,0,0,0); chk("t1_state_d", O_state, 1); chk("t1_dec", bus.O_decode_en, 1);
        chk("t1_ir_once", bus.O_ir_load, 0);
        cyc(0,0,0,0,0,0,0,0,0); chk("t1_state_e", O_state, 2); chk("t1_alu", bus.O_alu_en, 1);
        chk("t1_pce_ex", bus.O_pc_enable, 0);
        cyc(0,0,0,0,0,0,0,0,0); chk("t1_state_wb", O_state, 4); chk("t1_we", bus.O_reg_we, 1);
        chk("t1_pce_wb", bus.O_pc_enable, 1); chk("t1_pcw_wb", bus.O_pc_write, 0);
        $display("scenario alu: done");
        // Taken branch
        cyc(0,1,0,0,0,0,0,0,0); chk("t2_state_f", O_state, 0);
        cyc(0,0,0,1,0,0,0,0,0); chk("t2_state_d", O_state, 1);
        cyc(0,0,0,0,0,0,1,0,0); chk("t2_state_e", O_state, 2);
        chk("t2_pce", bus.O_pc_enable, 1); chk("t2_pcw", bus.O_pc_write, 1); chk("t2_pcs", bus.O_pc_sel, 0);
        cyc(0,0,0,0,0,0,0,0,0); chk("t2_state_wb", O_state, 4);
        chk("t2_no_inc", bus.O_pc_enable, 0); chk("t2_we", bus.O_reg_we, 0);
        $display("scenario branch: done");
        // Load with 4-cycle memory wait, then interrupt at writeback
        cyc(0,1,0,0,0,0,0,0,0); chk("t3_state_f", O_state, 0);
        cyc(0,0,1,0,0,1,0,0,0); chk("t3_state_d", O_state, 1);
        cyc(0,0,0,0,0,0,0,0,0); chk("t3_state_e", O_state, 2);
        for (int i = 0; i < 4; i++) begin
            cyc(0, (i == 3), 0,0,0,0,0,0,0);
            chk("t3_state_m", O_state, 3); chk("t3_sel", bus.O_mem_sel, 1); chk("t3_req", bus.O_mem_req, 1);
        end
        cyc(0,0,0,0,0,0,0,1,1); chk("t3_state_wb", O_state, 4); chk("t3_we", bus.O_reg_we, 1);
        cyc(0,0,0,0,0,0,0,0,0); chk("t3_state_irq", O_state, 5); chk("t3_ack", O_irq_ack, 1);
        chk("t3_pcs", bus.O_pc_sel, 1); chk("t3_pcw", bus.O_pc_write, 1); chk("t3_pce", bus.O_pc_enable, 1);
        cyc(0,0,0,0,0,0,0,0,0); chk("t3_state_f", O_state, 0); chk("t3_ack_off", O_irq_ack, 0);
        $display("scenario load+irq: done");
        // Interrupt masked at writeback
        cyc(0,1,0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,0,0,0); chk("t4_state_d", O_state, 1);
        cyc(0,0,0,0,0,0,0,0,0); chk("t4_state_e", O_state, 2);
        cyc(0,0,0,0,0,0,0,1,0); chk("t4_state_wb", O_state, 4);
        cyc(0,0,0,0,0,0,0,1,0); chk("t4_state_f", O_state, 0);
        $display("scenario masked irq: done");
        // HALT, held 10 cycles, then interrupt exit
        cyc(0,1,0,0,0,0,0,0,0);
        cyc(0,0,0,0,1,0,0,0,0); chk("t5_state_d", O_state, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0,0,0,0,0,0,0,1,0);
            chk("t5_state_h", O_state, 6); chk("t5_halted", O_halted, 1);
            chk("t5_pce", bus.O_pc_enable, 0); chk("t5_pcw", bus.O_pc_write, 0);
        end
        cyc(0,0,0,0,0,0,0,1,1); chk("t5_state_h_exit", O_state, 6);
        cyc(0,0,0,0,0,0,0,0,0); chk("t5_state_irq", O_state, 5); chk("t5_ack", O_irq_ack, 1);
        cyc(0,0,0,0,0,0,0,0,0); chk("t5_state_f1", O_state, 0);
        $display("scenario halt: done");
        // Fetch timeout: fault on the 5th waiting cycle, then irq ignored
        for (int i = 2; i <= 5; i++) begin
            cyc(0,0,0,0,0,0,0,0,0);
            chk("t6_state_f", O_state, 0); chk("t6_fault_lo", O_fault, 0);
        end
        cyc(0,0,0,0,0,0,0,1,1); chk("t6_state_h", O_state, 6); chk("t6_fault", O_fault, 1);
        chk("t6_halted", O_halted, 1);
        cyc(0,0,0,0,0,0,0,1,1); chk("t6_irq_ignored", O_state, 6);
        $display("scenario timeout: done");
        // Reset during a memory wait
        cyc(1,0,0,0,0,0,0,0,0);
        cyc(0,1,0,0,0,0,0,0,0); chk("t7_state_f", O_state, 0); chk("t7_fault", O_fault, 0);
        cyc(0,0,1,0,0,0,0,0,0); chk("t7_state_d", O_state, 1);
        cyc(0,0,0,0,0,0,0,0,0); chk("t7_state_e", O_state, 2);
        cyc(0,0,0,0,0,0,0,0,0); chk("t7_state_m", O_state, 3);
        cyc(1,0,0,0,0,0,0,0,0); chk("t7_state_m2", O_state, 3);
        cyc(0,0,0,0,0,0,0,0,0); chk("t7_state_rst", O_state, 0); chk("t7_fault_rst", O_fault, 0);
        chk("t7_sel", bus.O_mem_sel, 0); chk("t7_req", bus.O_mem_req, 1);
        $display("scenario reset mid-memory: done");
        // Random phase, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 4,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1);
        end
        $display("scenario random: 3000 cycles");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
